// File: rtl/frame_update_scheduler_pkg.sv
// Shared definitions for the frame update scheduler: FSM encoding, stage ids,
// default parameters and a saturating increment helper.
package frame_update_scheduler_pkg;

  typedef logic [1:0] fus_state_t;

  localparam fus_state_t ST_IDLE  = 2'd0;
  localparam fus_state_t ST_ISSUE = 2'd1;
  localparam fus_state_t ST_WAIT  = 2'd2;

  localparam int STG_PLAYER = 0;
  localparam int STG_PROJ   = 1;
  localparam int STG_ENEMY  = 2;
  localparam int STG_COLL   = 3;

  localparam int DEF_NUM_STAGES     = 4;
  localparam int DEF_VBLANK_LINE    = 480;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_FRAME_CNT_W    = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_update_scheduler_edge.sv
// frame_edge_detect: one-cycle pulse on the first cycle vCount equals the
// vblank line; reusable by any logic that needs a frame-start strobe.
module frame_edge_detect
  import frame_update_scheduler_pkg::*;
#(
  parameter int VBLANK_LINE = DEF_VBLANK_LINE,
  parameter int VCOUNT_W    = 10
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [VCOUNT_W-1:0] i_vcount,
  output logic                o_fs
);

  logic [VCOUNT_W-1:0] r_vcount_prev;
  logic                w_at_line;
  logic                w_was_at_line;

  // Previous line register, sampled every cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vcount_prev <= '0;
    end else begin
      r_vcount_prev <= i_vcount;
    end
  end

  assign w_at_line     = (i_vcount == VCOUNT_W'(VBLANK_LINE));
  assign w_was_at_line = (r_vcount_prev == VCOUNT_W'(VBLANK_LINE));
  assign o_fs          = w_at_line & ~w_was_at_line;

endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame ordered update sequencer with per-stage timeout and overrun detection.
// Optional per-frame cycle statistics are enabled with FRAME_SCHED_STATS_EN.
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int VBLANK_LINE    = DEF_VBLANK_LINE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FRAME_CNT_W    = DEF_FRAME_CNT_W
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [9:0]             i_vcount,
  input  logic                   i_game_playing,
  input  logic [NUM_STAGES-1:0]  i_stage_mask,
  input  logic [NUM_STAGES-1:0]  i_stage_done,
  output logic [NUM_STAGES-1:0]  o_update_en,
  output logic                   o_frame_tick,
  output logic                   o_busy,
  output logic                   o_timeout_flag,
  output logic                   o_overrun_flag,
  output logic [FRAME_CNT_W-1:0] o_frame_count,
  output logic [15:0]            o_last_frame_cycles,
  output logic [15:0]            o_max_frame_cycles
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  fus_state_t             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [TMR_W-1:0]       r_timer;
  logic                   r_timeout_flag;
  logic                   r_overrun_flag;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  fus_state_t             w_state_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [TMR_W-1:0]       w_timer_nxt;
  logic [NUM_STAGES-1:0]  w_update_en;
  logic                   w_frame_tick;
  logic                   w_timeout_hit;
  logic                   w_seq_done;
  logic                   w_fs;
  logic                   w_last_stage;
  logic                   w_timer_expired;

  frame_edge_detect #(
    .VBLANK_LINE (VBLANK_LINE),
    .VCOUNT_W    (10)
  ) u_edge (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_vcount (i_vcount),
    .o_fs     (w_fs)
  );

  assign w_last_stage    = (r_idx == LAST_IDX);
  assign w_timer_expired = (r_timer == TMR_LAST);

  // Sequencer next-state; losing game_playing aborts from any busy state.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_timer_nxt   = r_timer;
    w_update_en   = '0;
    w_frame_tick  = 1'b0;
    w_timeout_hit = 1'b0;
    w_seq_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fs && i_game_playing) begin
          w_frame_tick = 1'b1;
          w_idx_nxt    = '0;
          w_state_nxt  = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!i_game_playing) begin
          w_state_nxt = ST_IDLE;
        end else if (i_stage_mask[r_idx]) begin
          w_update_en[r_idx] = 1'b1;
          w_timer_nxt        = '0;
          w_state_nxt        = ST_WAIT;
        end else if (w_last_stage) begin
          w_state_nxt = ST_IDLE;
          w_seq_done  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        if (!i_game_playing) begin
          w_state_nxt = ST_IDLE;
        end else if (i_stage_done[r_idx] || w_timer_expired) begin
          // A done pulse on the expiry cycle still counts as a clean finish.
          w_timeout_hit = ~i_stage_done[r_idx];
          if (w_last_stage) begin
            w_state_nxt = ST_IDLE;
            w_seq_done  = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_timer        <= '0;
      r_timeout_flag <= 1'b0;
      r_overrun_flag <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_timer <= w_timer_nxt;
      if (w_frame_tick) begin
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
      if (w_timeout_hit) begin
        r_timeout_flag <= 1'b1;
      end
      if (w_fs && (r_state != ST_IDLE)) begin
        r_overrun_flag <= 1'b1;
      end
    end
  end

  assign o_update_en    = w_update_en & {NUM_STAGES{~i_reset}};
  assign o_frame_tick   = w_frame_tick & ~i_reset;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_timeout_flag = r_timeout_flag;
  assign o_overrun_flag = r_overrun_flag;
  assign o_frame_count  = r_frame_count;

`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] r_cyc;
  logic [15:0] r_last_cycles;
  logic [15:0] r_max_cycles;
  logic [15:0] w_cyc_final;

  assign w_cyc_final = sat_inc16(r_cyc);

  // Frame length counter: frame_tick cycle counts as 1, return cycle included.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cyc         <= 16'd0;
      r_last_cycles <= 16'd0;
      r_max_cycles  <= 16'd0;
    end else begin
      if (w_frame_tick) begin
        r_cyc <= 16'd1;
      end else if (r_state != ST_IDLE) begin
        r_cyc <= w_cyc_final;
      end
      if (w_seq_done) begin
        r_last_cycles <= w_cyc_final;
        if (w_cyc_final > r_max_cycles) begin
          r_max_cycles <= w_cyc_final;
        end
      end
    end
  end

  assign o_last_frame_cycles = r_last_cycles;
  assign o_max_frame_cycles  = r_max_cycles;
`else
  logic w_unused_seq_done;
  assign w_unused_seq_done   = w_seq_done;
  assign o_last_frame_cycles = 16'd0;
  assign o_max_frame_cycles  = 16'd0;
`endif

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler: table vectors, hand-written
// corner sequences and randomized frames against a schedule model.
module tb_frame_update_scheduler;
  import frame_update_scheduler_pkg::*;

  localparam int NS      = 4;
  localparam int TIMEOUT = 1024;

  logic          clk;
  logic          i_reset;
  logic [9:0]    i_vcount;
  logic          i_game_playing;
  logic [NS-1:0] i_stage_mask;
  logic [NS-1:0] i_stage_done;
  logic [NS-1:0] o_update_en;
  logic          o_frame_tick;
  logic          o_busy;
  logic          o_timeout_flag;
  logic          o_overrun_flag;
  logic [15:0]   o_frame_count;
  logic [15:0]   o_last_frame_cycles;
  logic [15:0]   o_max_frame_cycles;

  frame_update_scheduler dut (
    .i_clk               (clk),
    .i_reset             (i_reset),
    .i_vcount            (i_vcount),
    .i_game_playing      (i_game_playing),
    .i_stage_mask        (i_stage_mask),
    .i_stage_done        (i_stage_done),
    .o_update_en         (o_update_en),
    .o_frame_tick        (o_frame_tick),
    .o_busy              (o_busy),
    .o_timeout_flag      (o_timeout_flag),
    .o_overrun_flag      (o_overrun_flag),
    .o_frame_count       (o_frame_count),
    .o_last_frame_cycles (o_last_frame_cycles),
    .o_max_frame_cycles  (o_max_frame_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic          nx_reset;
  logic [9:0]    nx_vcount;
  logic          nx_gp;
  logic [NS-1:0] nx_mask;

  int cyc = 0;
  int n_ticks = 0;
  int cur_stage = -1;
  int done_at[NS];
  int lat_cur[NS];
  int q_cyc[$];
  int q_stg[$];

  int exp_cyc[$];
  int exp_stg[$];
  int exp_end;
  int exp_count = 0;
  logic exp_tmo = 1'b0;
  logic exp_ovr = 1'b0;
  int end_off;

  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] lats;
    logic [15:0] seq;
    int          np;
    int          len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, respond to pulses.
  task automatic step();
    logic [NS-1:0] d;
    @(posedge clk);
    cyc++;
    #1;
    i_reset        = nx_reset;
    i_vcount       = nx_vcount;
    i_game_playing = nx_gp;
    i_stage_mask   = nx_mask;
    for (int s = 0; s < NS; s++) begin
      d[s] = (done_at[s] == cyc) || ((s < cur_stage) && ($urandom_range(0, 3) == 0));
    end
    i_stage_done = d;
    @(negedge clk);
    if (o_frame_tick) begin
      n_ticks++;
      cur_stage = -1;
      for (int s = 0; s < NS; s++) done_at[s] = -1;
    end
    if (o_update_en != '0) begin
      chk("onehot", $countones(o_update_en), 1);
      for (int s = 0; s < NS; s++) begin
        if (o_update_en[s]) begin
          q_cyc.push_back(cyc);
          q_stg.push_back(s);
          cur_stage = s;
          if (lat_cur[s] > 0) done_at[s] = cyc + lat_cur[s];
        end
      end
    end
  endtask

  // Expected schedule: enabled stage costs 1 issue cycle plus its wait length.
  function automatic void model_frame(input int t0, input logic [NS-1:0] m);
    int t;
    int w;
    t = t0 + 1;
    exp_cyc.delete();
    exp_stg.delete();
    for (int s = 0; s < NS; s++) begin
      if (m[s]) begin
        exp_cyc.push_back(t);
        exp_stg.push_back(s);
        if (lat_cur[s] == 0 || lat_cur[s] > TIMEOUT) begin
          w = TIMEOUT;
          exp_tmo = 1'b1;
        end else begin
          w = lat_cur[s];
        end
        t = t + 1 + w;
      end else begin
        t = t + 1;
      end
    end
    exp_end = t;
  endfunction

  task automatic run_frame(input logic [NS-1:0] m);
    int t0;
    int tb;
    nx_mask = m; nx_gp = 1'b1; nx_vcount = 10'd479;
    step();
    q_cyc.delete(); q_stg.delete();
    tb = n_ticks;
    nx_vcount = 10'd480;
    step();
    chk("frame_tick", n_ticks - tb, 1);
    t0 = cyc;
    exp_count++;
    model_frame(t0, m);
    for (int k = 0; k < 3000; k++) begin
      step();
      if (!o_busy) break;
    end
    end_off = cyc - t0;
    chk("busy_len", end_off, exp_end - t0);
    chk("n_pulses", q_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < q_cyc.size(); i++) begin
      chk("pulse_cyc", q_cyc[i], exp_cyc[i]);
      chk("pulse_stg", q_stg[i], exp_stg[i]);
    end
    chk("timeout_flag", o_timeout_flag, exp_tmo);
    chk("overrun_flag", o_overrun_flag, exp_ovr);
    chk("frame_count", o_frame_count, exp_count);
    chk("ticks_in_frame", n_ticks - tb, 1);
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int e);
    lat_cur[0] = a; lat_cur[1] = b; lat_cur[2] = c; lat_cur[3] = e;
  endtask

  initial begin
    int tb;
    int np;
    int t0;
    bit found;
    vec_t v;

    vecs[0] = '{4'hF, 16'h3333, 16'h3210, 4, 17};
    vecs[1] = '{4'hF, 16'h1111, 16'h3210, 4, 9};
    vecs[2] = '{4'hB, 16'h1111, 16'h0310, 3, 8};
    vecs[3] = '{4'h0, 16'h1111, 16'h0000, 0, 5};
    vecs[4] = '{4'h8, 16'h2222, 16'h0003, 1, 7};
    vecs[5] = '{4'h5, 16'h1411, 16'h0020, 2, 10};

    for (int s = 0; s < NS; s++) begin
      done_at[s] = -1;
      lat_cur[s] = 1;
    end
    i_reset = 1'b1; i_vcount = 10'd0; i_game_playing = 1'b0;
    i_stage_mask = '0; i_stage_done = '0;
    nx_reset = 1'b1; nx_vcount = 10'd0; nx_gp = 1'b0; nx_mask = '0;
    repeat (3) step();
    nx_reset = 1'b0;
    step();
    chk("rst_update_en", o_update_en, 0);
    chk("rst_frame_tick", o_frame_tick, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout_flag, 0);
    chk("rst_overrun", o_overrun_flag, 0);
    chk("rst_count", o_frame_count, 0);
    chk("rst_last_cycles", o_last_frame_cycles, 0);

    // Table-driven frames.
    for (int r = 0; r < 6; r++) begin
      v = vecs[r];
      for (int s = 0; s < NS; s++) lat_cur[s] = int'(v.lats[4*s +: 4]);
      run_frame(v.mask);
      chk("tbl_len", end_off, v.len);
      chk("tbl_np", q_stg.size(), v.np);
      for (int k = 0; k < v.np && k < q_stg.size(); k++) begin
        chk("tbl_stage", q_stg[k], v.seq[4*k +: 4]);
      end
      if (r == 0) begin
`ifdef FRAME_SCHED_STATS_EN
        chk("last_frame_cycles", o_last_frame_cycles, 17);
`else
        chk("last_frame_cycles", o_last_frame_cycles, 0);
`endif
      end
    end

    // Hold vCount at the vblank line: exactly one tick.
    set_lat(1, 1, 1, 1);
    nx_mask = 4'hF; nx_gp = 1'b1; nx_vcount = 10'd479;
    step();
    tb = n_ticks;
    nx_vcount = 10'd480;
    step();
    exp_count++;
    repeat (400) step();
    chk("hold_ticks", n_ticks - tb, 1);
    chk("hold_count", o_frame_count, exp_count);
    nx_gp = 1'b0; nx_vcount = 10'd479;
    step();
    tb = n_ticks;
    nx_vcount = 10'd480;
    repeat (6) step();
    chk("gp0_ticks", n_ticks - tb, 0);
    chk("gp0_count", o_frame_count, exp_count);
    chk("gp0_busy", o_busy, 0);
    nx_gp = 1'b1;
    step();

    // Done coinciding with the last timer cycle counts as done.
    set_lat(1, TIMEOUT, 1, 1);
    run_frame(4'hF);
    if (q_cyc.size() >= 3) chk("bnd_gap", q_cyc[2] - q_cyc[1], 1025);
    chk("bnd_no_tmo", o_timeout_flag, 0);

    // Withheld done forces the timeout.
    set_lat(1, 0, 1, 1);
    run_frame(4'hF);
    if (q_cyc.size() >= 3) chk("tmo_gap", q_cyc[2] - q_cyc[1], 1025);
    chk("tmo_flag", o_timeout_flag, 1);
    set_lat(1, 1, 1, 1);
    run_frame(4'hF);
    chk("tmo_sticky", o_timeout_flag, 1);

    // Overrun while stage 0 waits, then abort.
    set_lat(0, 1, 1, 1);
    nx_mask = 4'hF; nx_vcount = 10'd479;
    step();
    tb = n_ticks;
    nx_vcount = 10'd480;
    step();
    chk("ovr_first_tick", n_ticks - tb, 1);
    exp_count++;
    repeat (3) step();
    nx_vcount = 10'd0;
    step();
    tb = n_ticks;
    nx_vcount = 10'd480;
    step();
    chk("ovr_no_tick", n_ticks - tb, 0);
    step();
    exp_ovr = 1'b1;
    chk("ovr_flag", o_overrun_flag, 1);
    chk("ovr_count", o_frame_count, exp_count);
    chk("ovr_busy", o_busy, 1);
    np = q_cyc.size();
    nx_gp = 1'b0;
    step();
    step();
    chk("abort_idle", o_busy, 0);
    repeat (20) step();
    chk("abort_no_pulse", q_cyc.size(), np);
    nx_gp = 1'b1;
    step();

    // Abort landing on an ISSUE cycle must suppress that pulse.
    set_lat(1, 1, 1, 1);
    nx_vcount = 10'd479;
    step();
    q_cyc.delete(); q_stg.delete();
    nx_vcount = 10'd480;
    step();
    exp_count++;
    step();
    step();
    nx_gp = 1'b0;
    step();
    chk("abort_issue_pulses", q_cyc.size(), 1);
    step();
    chk("abort_issue_idle", o_busy, 0);
    repeat (10) step();
    chk("abort_issue_after", q_cyc.size(), 1);
    chk("abort_ovr_kept", o_overrun_flag, 1);
    nx_gp = 1'b1;
    step();

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      for (int s = 0; s < NS; s++) lat_cur[s] = int'($urandom_range(1, 6));
      run_frame(4'($urandom_range(0, 15)));
    end

    // Reset during stage 2 wait.
    set_lat(3, 3, 3, 3);
    nx_mask = 4'hF; nx_vcount = 10'd479;
    step();
    q_cyc.delete(); q_stg.delete();
    nx_vcount = 10'd480;
    step();
    t0 = cyc;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (q_stg.size() > 0 && q_stg[q_stg.size()-1] == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_reach_stage2", found, 1);
    chk("rst_stage2_cyc", cyc - t0, 9);
    step();
    nx_reset = 1'b1; nx_vcount = 10'd0;
    step();
    nx_reset = 1'b0;
    step();
    chk("mid_rst_update_en", o_update_en, 0);
    chk("mid_rst_frame_tick", o_frame_tick, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_timeout", o_timeout_flag, 0);
    chk("mid_rst_overrun", o_overrun_flag, 0);
    chk("mid_rst_count", o_frame_count, 0);
    for (int s = 0; s < NS; s++) done_at[s] = -1;
    exp_count = 0; exp_tmo = 1'b0; exp_ovr = 1'b0;
    set_lat(1, 1, 1, 1);
    run_frame(4'hF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Sequences the per-frame game-object updates (player, projectile, enemy fleet, collisions) once per video frame, during vertical blank.
- Sits between display_controller (vCount) and the game-object modules; replaces their free-running updates with a strict, ordered, handshaked schedule.
- Flags frames whose update sequence does not finish before the next frame boundary.

Parameters:
- NUM_STAGES, 4, number of sequenced update stages; stage 0 runs first (0=player, 1=projectile, 2=enemy, 3=collision).
- VBLANK_LINE, 480, vCount value that marks frame start.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles per stage before forced advance; minimum 2.
- FRAME_CNT_W, 16, frame counter width.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high.
- vCount  in  10  current video line from display_controller.
- game_playing  in  1  game FSM in PLAYING state; sequencing runs only while high.
- stage_mask  in  NUM_STAGES  1 = stage enabled; 0 = stage skipped this frame.
- stage_done  in  NUM_STAGES  1-cycle completion pulse per stage.
- update_en  out  NUM_STAGES  one-hot, 1-cycle start pulse to the current stage.
- frame_tick  out  1  1-cycle pulse at each accepted frame start.
- busy  out  1  high from the cycle after frame_tick until the sequence ends.
- timeout_flag  out  1  sticky; set when any stage hits TIMEOUT_CYCLES.
- overrun_flag  out  1  sticky; set when a frame start arrives while busy.
- frame_count  out  FRAME_CNT_W  accepted frames, wraps modulo 2^FRAME_CNT_W.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, stage index 0, timer 0, registered vCount_prev 0.
- Frame start: fs = (vCount == VBLANK_LINE) && (vCount_prev != VBLANK_LINE). vCount_prev is registered every cycle. fs fires once per frame even though vCount holds its value for many cycles.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - On fs with game_playing=1: frame_tick=1 for that cycle, frame_count+1, stage index to 0, go to ISSUE.
  - On fs with game_playing=0: no action.
- ISSUE:
  - If stage_mask[idx]=1: assert update_en[idx] for exactly this cycle, load timer to 0, go to WAIT.
  - If stage_mask[idx]=0: no pulse, advance idx. If idx was NUM_STAGES-1, go to IDLE instead.
  - stage_done is ignored in this state.
- WAIT:
  - If stage_done[idx]=1, or timer==TIMEOUT_CYCLES-1 (which also sets timeout_flag): advance. Next state is ISSUE with idx+1, or IDLE if idx was the last stage.
  - Otherwise timer+1.
  - stage_done bits for other stages are ignored.
- Minimum latency per enabled stage: pulse cycle + 1 WAIT cycle. A 4-stage frame with immediate done pulses completes in 8 cycles after frame_tick.
- busy = (state != IDLE).
- Overrun: fs while not IDLE sets overrun_flag. That frame is dropped: no frame_tick, no count increment, and the current sequence continues.
- Abort: if game_playing falls while not IDLE, go to IDLE on the next edge; no further update_en pulses. Sticky flags are kept.
- Sticky flags clear only on reset.
- Reset mid-sequence: the synchronous reset wins over every transition.
- Simultaneous done and timeout in the same cycle: counts as done; timeout_flag is not set.

Optional Feature:
- FRAME_SCHED_STATS_EN defined:
  - Adds outputs last_frame_cycles[15:0] and max_frame_cycles[15:0]: cycles from frame_tick to return to IDLE (inclusive of the return cycle), saturating at 16'hFFFF.
  - last_frame_cycles updates on each completion; max_frame_cycles holds the maximum since reset.
  - Aborted sequences do not update either output.
- Undefined: both ports exist but are tied to 0; no counters are synthesized.

Decomposition:
- Shared package: FSM state encoding (IDLE/ISSUE/WAIT), stage index constants STG_PLAYER=0, STG_PROJ=1, STG_ENEMY=2, STG_COLL=3, default VBLANK_LINE.
- One sub-module: frame_edge_detect (vCount compare + registered previous value → fs pulse), reusable by the graphics logic.

Test Plan:
- Nominal: game_playing=1, mask=4'b1111, each stage_done returned 3 cycles after its update_en. Step vCount 479→480 → one frame_tick, update_en pulses 0001, 0010, 0100, 1000 in order, busy falls 16 cycles after frame_tick, frame_count=1.
- Hold: hold vCount=480 for 400 cycles → exactly one frame_tick. Drop game_playing=0 and step vCount to 480 again → no frame_tick, frame_count unchanged.
- Skip: mask=4'b1011, immediate done pulses → update_en shows 0001, 0010, 1000 only; never 0100.
- Timeout: withhold stage_done[1] with TIMEOUT_CYCLES=1024 → stage 2 pulse occurs 1024 WAIT cycles after the stage-1 pulse, timeout_flag=1 and stays 1 through the next frame.
- Overrun and abort: withhold done, force a second fs → overrun_flag=1, frame_count unchanged. Then drop game_playing → IDLE next cycle, no further update_en pulses.
- Reset: assert reset during WAIT of stage 2 → all outputs 0 on the next edge, flags cleared. With FRAME_SCHED_STATS_EN defined, the nominal frame gives last_frame_cycles=17.
